// File: rtl/wb_pkg.sv
// Shared constants and the write-back request record used by the write-port arbiter.
package wb_pkg;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO of write-back requests; head is the oldest entry, valid when !empty.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter type T     = wb_req_t,
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output logic [CW-1:0] count,
  output T              head,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by count, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline write-back and a queued long-latency unit.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int RADDR      = wb_pkg::RADDR,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_valid,
  input  logic [RADDR-1:0] pipe_rd,
  input  logic [XLEN-1:0]  pipe_data,
  output logic             pipe_stall,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [RADDR-1:0] lu_rd,
  input  logic [XLEN-1:0]  lu_data,
  output logic             rf_we,
  output logic [RADDR-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata
);

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  data;
  } entry_t;

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] QDEPTH_C    = CW'(QDEPTH);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  entry_t          q_din;
  entry_t          q_head;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            pipe_req;
  logic            q_req;
  logic            forced;
  logic            head_win;
  logic            pipe_win;
  logic [SW-1:0]   starve_cnt;

  assign q_din  = '{valid: 1'b1, rd: lu_rd, data: lu_data};
  // Intake depends only on reset and the pre-pop occupancy, so a full queue refuses even when it pops.
  assign lu_ready = !rst && (q_count < QDEPTH_C);
  assign q_push   = lu_valid && lu_ready && (lu_rd != '0);

  wb_result_fifo #(
    .T     (entry_t),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (head_win),
    .din   (q_din),
    .count (q_count),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pipe_req   = pipe_valid && (pipe_rd != '0);
    q_req      = !q_empty && q_head.valid;
    forced     = (starve_cnt == STARVE_LAST) || q_full;
    head_win   = 1'b0;
    pipe_win   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pipe_stall = 1'b0;
    if (!rst) begin
      if (q_req && (!pipe_req || forced)) begin
        head_win   = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = q_head.rd;
        rf_wdata   = q_head.data;
        pipe_stall = pipe_req;
      end else if (pipe_req) begin
        pipe_win = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || head_win || q_empty) begin
      starve_cnt <= '0;
    end else if (q_req && pipe_win && (starve_cnt != STARVE_LAST)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven check of the write-port arbiter plus a hand-written reset-flush sequence.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN       (32),
    .RADDR      (5),
    .QDEPTH     (2),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  typedef struct {
    logic        rst;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic pv, logic [4:0] prd, logic [31:0] pd,
                             logic lv, logic [4:0] lrd, logic [31:0] ld,
                             logic we, logic [4:0] wa, logic [31:0] wd,
                             logic stall, logic rdy);
    vec_t t;
    t.rst = r;  t.pv = pv; t.prd = prd; t.pd = pd;
    t.lv = lv;  t.lrd = lrd; t.ld = ld;
    t.we = we;  t.wa = wa; t.wd = wd; t.stall = stall; t.rdy = rdy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input logic r, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    rst = r; pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic stall, input logic rdy);
    @(negedge clk);
    check({tag, ".we"},    32'(rf_we),      32'(we));
    check({tag, ".waddr"}, 32'(rf_waddr),   32'(wa));
    check({tag, ".wdata"}, rf_wdata,        wd);
    check({tag, ".stall"}, 32'(pipe_stall), 32'(stall));
    check({tag, ".ready"}, 32'(lu_ready),   32'(rdy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    repeat (2) @(posedge clk);

    //                rst pv prd pd            lv lrd ld          we wa wd            st rdy
    vecs.push_back(v(1, 1, 5, 32'hA5A5A5A5, 1, 7, 32'h77,       0, 0, 32'h0,        0, 0));
    vecs.push_back(v(0, 1, 5, 32'hA5A5A5A5, 0, 0, 32'h0,        1, 5, 32'hA5A5A5A5, 0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 7, 32'h11,       0, 0, 32'h0,        0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 32'h11,       0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 1));
    // Starvation: one queued entry loses three times, then is forced through.
    vecs.push_back(v(0, 1, 3, 32'h30,       1, 9, 32'h99,       1, 3, 32'h30,       0, 1));
    vecs.push_back(v(0, 1, 3, 32'h31,       0, 0, 32'h0,        1, 3, 32'h31,       0, 1));
    vecs.push_back(v(0, 1, 3, 32'h32,       0, 0, 32'h0,        1, 3, 32'h32,       0, 1));
    vecs.push_back(v(0, 1, 3, 32'h33,       0, 0, 32'h0,        1, 3, 32'h33,       0, 1));
    vecs.push_back(v(0, 1, 3, 32'h34,       0, 0, 32'h0,        1, 9, 32'h99,       1, 1));
    vecs.push_back(v(0, 1, 3, 32'h34,       0, 0, 32'h0,        1, 3, 32'h34,       0, 1));
    // Full queue forces the head immediately and blocks intake that cycle.
    vecs.push_back(v(0, 1, 4, 32'h40,       1, 10, 32'hA0,      1, 4, 32'h40,       0, 1));
    vecs.push_back(v(0, 1, 4, 32'h41,       1, 11, 32'hB0,      1, 4, 32'h41,       0, 1));
    vecs.push_back(v(0, 1, 4, 32'h42,       1, 12, 32'hC0,      1, 10, 32'hA0,      1, 0));
    vecs.push_back(v(0, 1, 4, 32'h42,       1, 12, 32'hC0,      1, 4, 32'h42,       0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 11, 32'hB0,      0, 0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 12, 32'hC0,      0, 1));
    // rd==0 on both sources, then a queued head beside a pipe rd==0 retire.
    vecs.push_back(v(0, 1, 0, 32'hDEAD,     1, 0, 32'hBEEF,     0, 0, 32'h0,        0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 13, 32'hD0,      0, 0, 32'h0,        0, 1));
    vecs.push_back(v(0, 1, 0, 32'hEE,       0, 0, 32'h0,        1, 13, 32'hD0,      0, 1));
    // Same rd from both sources: pipe first, LU overwrites next cycle.
    vecs.push_back(v(0, 1, 6, 32'h60,       1, 6, 32'h66,       1, 6, 32'h60,       0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 6, 32'h66,       0, 1));
    // Back-to-back push with pop keeps order.
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 14, 32'hE0,      0, 0, 32'h0,        0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 15, 32'hF0,      1, 14, 32'hE0,      0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 16, 32'h100,     1, 15, 32'hF0,      0, 1));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 16, 32'h100,     0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].prd, vecs[i].pd,
            vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      check_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                 vecs[i].stall, vecs[i].rdy);
    end

    // Reset with two queued entries: they must vanish without being written.
    drive(0, 1, 2, 32'h20, 1, 17, 32'h170);
    check_outs("rstseq.q1", 1, 2, 32'h20, 0, 1);
    drive(0, 1, 2, 32'h21, 1, 18, 32'h180);
    check_outs("rstseq.q2", 1, 2, 32'h21, 0, 1);
    drive(1, 1, 2, 32'h21, 1, 19, 32'h190);
    check_outs("rstseq.inrst", 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("rstseq.post1", 0, 0, 32'h0, 0, 1);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_outs("rstseq.post2", 0, 0, 32'h0, 0, 1);
    drive(0, 1, 8, 32'h88, 0, 0, 32'h0);
    check_outs("rstseq.pipe", 1, 8, 32'h88, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
